// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bridge.
// Contents: the bridge FSM state type, the register map addresses,
// the position of the read/write flag in the command byte, and a
// helper that tells whether an address is backed by a register.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ
  } state_e;

  localparam logic [6:0] ADDR_LED     = 7'h00;
  localparam logic [6:0] ADDR_PMOD    = 7'h01;
  localparam logic [6:0] ADDR_SCRATCH = 7'h02;
  localparam logic [6:0] ADDR_ID      = 7'h03;
  localparam logic [6:0] ADDR_ERR     = 7'h04;

  localparam int CMD_RW_BIT = 7;

  // Addresses 0x00..0x04 are mapped; everything above is an error access.
  function automatic logic is_mapped(input logic [6:0] addr);
    return addr <= ADDR_ERR;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, W bits wide.
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high; clears both stages
//   i_d    - asynchronous input
//   o_q    - synchronised output (two clk cycles of latency)
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift;
      // blocking ones would collapse both flops into one.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// Register bridge behind an SPI slave byte shifter.
// A frame is one frame_act-high window. Byte 0 is a command
// {rw, addr[6:0]}; the following bytes are burst data. Writes store each
// data byte at the current address; reads return reg[addr] to the shifter
// one cycle after the triggering byte. The address auto-increments and
// wraps at 7 bits.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   frame_act   - high while cs_n is low (already synchronised)
//   rx_valid    - one-cycle pulse, rx_data holds a received byte
//   rx_data     - received byte
//   tx_data     - next byte for the shifter to send
//   tx_valid    - one-cycle pulse, tx_data was just updated
//   led         - LED register (address 0x00)
//   pmod        - asynchronous PMOD pins, readable at address 0x01
//   err_cnt     - saturating count of unmapped accesses
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         LED_W    = 5,
  parameter int         PMOD_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_act,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic [LED_W-1:0]  led,
  input  logic [PMOD_W-1:0] pmod,
  output logic [7:0]        err_cnt
);

  state_e r_state;
  state_e w_next;

  logic              r_frame_q;
  logic [6:0]        r_addr;
  logic              r_load;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic [LED_W-1:0]  r_led;
  logic [7:0]        r_scratch;
  logic [7:0]        r_err_cnt;
  logic [PMOD_W-1:0] w_pmod_sync;

  logic       w_frame_rise;
  logic       w_cmd_fire;
  logic       w_wr_fire;
  logic       w_rd_step;
  logic       w_load_now;
  logic       w_err_inc;
  logic [7:0] w_rd_data;

  sync_2ff #(.W(PMOD_W)) u_pmod_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (pmod),
    .o_q   (w_pmod_sync)
  );

  assign w_frame_rise = frame_act & ~r_frame_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // A falling frame_act wins over a coincident rx_valid in every active
  // state, so an aborted byte never fires a command, write or read step.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no
    // path leaves a signal unassigned, which would infer a latch.
    w_next     = r_state;
    w_cmd_fire = 1'b0;
    w_wr_fire  = 1'b0;
    w_rd_step  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_frame_rise) w_next = ST_CMD;
      ST_CMD: begin
        if (!frame_act) w_next = ST_IDLE;
        else if (rx_valid) begin
          w_cmd_fire = 1'b1;
          w_next     = rx_data[CMD_RW_BIT] ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!frame_act)    w_next    = ST_IDLE;
        else if (rx_valid) w_wr_fire = 1'b1;
      end
      ST_READ: begin
        if (!frame_act)    w_next    = ST_IDLE;
        else if (rx_valid) w_rd_step = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The read load happens the cycle after the command or dummy byte, once
  // r_addr already holds the address to be returned.
  assign w_load_now = r_load & (r_state == ST_READ) & frame_act;
  assign w_err_inc  = (w_wr_fire | w_load_now) & ~is_mapped(r_addr);

  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      ADDR_LED:     w_rd_data = 8'(r_led);
      ADDR_PMOD:    w_rd_data = 8'(w_pmod_sync);
      ADDR_SCRATCH: w_rd_data = r_scratch;
      ADDR_ID:      w_rd_data = ID_VALUE;
      ADDR_ERR:     w_rd_data = r_err_cnt;
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Held high through reset so a frame already active at release is
      // not seen as a rising edge and is therefore not re-entered.
      r_frame_q  <= 1'b1;
      r_addr     <= 7'h00;
      r_load     <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_led      <= '0;
      r_scratch  <= 8'h00;
      r_err_cnt  <= 8'h00;
    end else begin
      r_frame_q  <= frame_act;
      r_load     <= (w_cmd_fire & rx_data[CMD_RW_BIT]) | w_rd_step;
      r_tx_valid <= w_load_now;

      if (w_cmd_fire)                  r_addr <= rx_data[6:0];
      else if (w_wr_fire | w_rd_step)  r_addr <= r_addr + 7'd1;

      if (w_load_now) r_tx_data <= w_rd_data;

      // Read-only and unmapped addresses simply have no write branch.
      if (w_wr_fire) begin
        case (r_addr)
          ADDR_LED:     r_led     <= rx_data[LED_W-1:0];
          ADDR_SCRATCH: r_scratch <= rx_data;
          default: ;
        endcase
      end

      if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign led      = r_led;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a transaction-level model of the
// register map predicts every transmitted byte (with its cycle) and the
// led / err_cnt outputs, and a negedge process compares every cycle.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_act = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [4:0] led;
  logic [7:0] pmod_val = 8'h00;
  logic [7:0] err_cnt;

  spi_reg_bridge #(.ID_VALUE(8'hA5), .LED_W(5), .PMOD_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_act (frame_act),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .led       (led),
    .pmod      (pmod_val),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         due;
    logic [7:0] data;
    bit         unmapped;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_log[$];
  logic [4:0] m_led = '0;
  logic [7:0] m_scratch = '0;
  logic [7:0] m_err = '0;
  logic [7:0] m_tx = '0;
  bit         m_active = 0;
  bit         m_have_cmd = 0;
  bit         m_rw = 0;
  logic [6:0] m_addr = '0;

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h00:   return {3'b000, m_led};
      7'h01:   return pmod_val;
      7'h02:   return m_scratch;
      7'h03:   return 8'hA5;
      7'h04:   return m_err;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void err_bump();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  function automatic void push_read(input logic [6:0] a);
    exp_t e;
    e.due      = cyc + 1;
    e.data     = model_read(a);
    e.unmapped = (a > 7'h04);
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_active) return;
    if (!m_have_cmd) begin
      m_have_cmd = 1;
      m_rw       = b[7];
      m_addr     = b[6:0];
      if (m_rw) push_read(m_addr);
    end else if (!m_rw) begin
      case (m_addr)
        7'h00:               m_led = b[4:0];
        7'h02:               m_scratch = b;
        7'h01, 7'h03, 7'h04: ;
        default:             err_bump();
      endcase
      m_addr = m_addr + 7'd1;
    end else begin
      m_addr = m_addr + 7'd1;
      push_read(m_addr);
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("reset_state", {tx_valid, led, err_cnt, tx_data}, 32'h0);
    end else begin
      bit exp_v;
      exp_t e;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("tx_valid", tx_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        m_tx = e.data;
        if (e.unmapped) err_bump();
        tx_log.push_back(tx_data);
      end
      check("tx_data", tx_data, m_tx);
      check("led", led, m_led);
      check("err_cnt", err_cnt, m_err);
    end
  end

  // ---------------- drivers (all start at a posedge) ----------------
  task automatic frame_start();
    #1 frame_act = 1'b1;
    m_active   = 1;
    m_have_cmd = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame_end();
    #1 frame_act = 1'b0;
    m_active = 0;
    repeat (2) @(posedge clk);
  endtask

  // One byte, optionally with frame_act dropping in the same cycle.
  task automatic send_byte(input logic [7:0] b, input bit abort);
    #1 rx_valid = 1'b1;
    rx_data = b;
    if (abort) begin
      frame_act = 1'b0;
      m_active  = 0;
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    rx_data = 8'h00;
    model_byte(b);
    repeat (2) @(posedge clk);
  endtask

  task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                       input logic [7:0] b2 = 8'h00);
    frame_start();
    send_byte(b0, 0);
    if (n > 1) send_byte(b1, 0);
    if (n > 2) send_byte(b2, 0);
    frame_end();
  endtask

  task automatic set_pmod(input logic [7:0] v);
    #1 pmod_val = v;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [6:0] addr;
    int n;
    bit abort;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    check("init_led", led, 5'h00);
    check("init_err", err_cnt, 8'h00);

    // LED write
    frame(2, 8'h00, 8'h15);
    check("led_write", led, 5'h15);
    check("led_write_err", err_cnt, 8'h00);

    // Burst read from scratch
    frame(2, 8'h02, 8'h3C);
    tx_log.delete();
    frame(3, 8'h82, 8'h00, 8'h00);
    check("burst_n", tx_log.size(), 3);
    check("burst_0", tx_log[0], 8'h3C);
    check("burst_1", tx_log[1], 8'hA5);
    check("burst_2", tx_log[2], 8'h00);

    // Wrap through unmapped 0x7F into led and pmod
    set_pmod(8'h5A);
    tx_log.delete();
    frame(3, 8'hFF, 8'h00, 8'h00);
    check("wrap_0", tx_log[0], 8'h00);
    check("wrap_1", tx_log[1], 8'h15);
    check("wrap_2", tx_log[2], 8'h5A);
    check("wrap_err", err_cnt, 8'h01);

    // Abort coincident with a data byte
    frame_start();
    send_byte(8'h02, 0);
    send_byte(8'h99, 1);
    repeat (2) @(posedge clk);
    tx_log.delete();
    frame(1, 8'h82);
    check("abort_scratch", tx_log[0], 8'h3C);

    // pmod read and read-only write
    tx_log.delete();
    frame(2, 8'h81, 8'h00);
    check("pmod_read", tx_log[0], 8'h5A);
    frame(2, 8'h03, 8'h00);
    tx_log.delete();
    frame(1, 8'h83);
    check("id_after_ro_write", tx_log[0], 8'hA5);
    check("ro_write_err", err_cnt, 8'h01);

    // Randomised frames
    for (int f = 0; f < 150; f++) begin
      set_pmod(8'($urandom));
      addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom_range(0, 6));
      n     = $urandom_range(0, 4);
      abort = ($urandom_range(0, 5) == 0);
      frame_start();
      send_byte({1'($urandom), addr}, abort && n == 0);
      for (int k = 0; k < n; k++) send_byte(8'($urandom), abort && k == n - 1);
      if (!abort) frame_end();
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 0);
    end

    // Saturation of err_cnt with unmapped write bursts
    for (int f = 0; f < 5; f++) begin
      frame_start();
      send_byte(8'h40, 0);
      for (int k = 0; k < 59; k++) send_byte(8'($urandom), 0);
      frame_end();
    end
    check("err_saturated", err_cnt, 8'hFF);

    // Reset in the middle of a write burst
    frame_start();
    send_byte(8'h00, 0);
    send_byte(8'h1F, 0);
    #3 reset = 1'b1;
    m_led = '0; m_scratch = '0; m_err = '0; m_tx = '0;
    m_active = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    send_byte(8'h12, 0);
    send_byte(8'h13, 0);
    check("post_reset_led", led, 5'h00);
    check("post_reset_txv", tx_valid, 1'b0);
    frame_end();
    frame(2, 8'h02, 8'h77);
    tx_log.delete();
    frame(2, 8'h82, 8'h00);
    check("post_reset_scratch", tx_log[0], 8'h77);
    check("post_reset_err", err_cnt, 8'h00);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
